// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and tag layout for the instruction fetch unit
// Contents: EPOCH_W, TAG_W, EPOCH_LSB, ifetch_entry_t, make_tag()
package ifetch_pkg;

    localparam int unsigned EPOCH_W   = 3;
    localparam int unsigned TAG_W     = 9;
    localparam int unsigned EPOCH_LSB = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifetch_entry_t;

    // Tag carries only the epoch; every other tag bit is zero.
    function automatic logic [TAG_W-1:0] make_tag(input logic [EPOCH_W-1:0] epoch);
        logic [TAG_W-1:0] tag;
        tag = '0;
        tag[EPOCH_LSB +: EPOCH_W] = epoch;
        return tag;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - synchronous prefetch FIFO of {pc, instr} entries
// Ports: clock/reset_n; push + wdata; pop; flush (highest priority, empties queue);
//        head (oldest entry), count, empty, full.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      push,
    input  ifetch_entry_t             wdata,
    input  logic                      pop,
    input  logic                      flush,
    output ifetch_entry_t             head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifetch_entry_t    mem_q [DEPTH];
    ifetch_entry_t    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch PC, epoch and credit logic in front of the prefetch queue
// Ports: clock/reset_n; ifetch_iram_* request/response to instruction_ram;
//        jump_valid/jump_address redirect; if_valid/if_ready/if_instr/if_pc to decoder.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             ifetch_iram_request,
    input  logic             ifetch_iram_ready,
    output logic [31:0]      ifetch_iram_address,
    output logic [31:0]      ifetch_iram_wdata,
    input  logic             ifetch_iram_rvalid,
    input  logic [31:0]      ifetch_iram_rdata,
    input  logic [31:0]      ifetch_iram_raddr,
    input  logic [TAG_W-1:0] ifetch_iram_rtag,
    input  logic             jump_valid,
    input  logic [31:0]      jump_address,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned CRED_W = CNT_W + 1;

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic [CNT_W-1:0]   q_count;
    logic               q_empty, q_full;
    ifetch_entry_t      q_head, q_wdata;
    logic               issue, rsp_seen, push, pop;
    logic [CRED_W-1:0]  credit_used;
    logic               unused_bits;

    always_comb begin
        credit_used = {1'b0, q_count} + {1'b0, inflight_q};
        // reset_n gates the request so nothing is offered while held in reset.
        issue    = reset_n && ifetch_iram_ready && (credit_used < CRED_W'(DEPTH)) && !jump_valid;
        // A response with no outstanding request is ignored; this keeps inflight from underflowing.
        rsp_seen = ifetch_iram_rvalid && (inflight_q != '0);
        push     = rsp_seen && (ifetch_iram_rtag[EPOCH_LSB +: EPOCH_W] == epoch_q) && !jump_valid;
        pop      = !q_empty && if_ready && !jump_valid;
        q_wdata  = '{pc: ifetch_iram_raddr, instr: ifetch_iram_rdata};

        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        if (jump_valid) begin
            fetch_pc_d = {jump_address[31:2], 2'b00};
            epoch_d    = epoch_q + EPOCH_W'(1);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // Redirect leaves inflight alone: stale responses still return and must be counted off.
        case ({issue, rsp_seen})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= {RESET_PC[31:2], 2'b00};
            epoch_q    <= '0;
            inflight_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            inflight_q <= inflight_d;
        end
    end

    ifetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (q_wdata),
        .pop     (pop),
        .flush   (jump_valid),
        .head    (q_head),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full)
    );

    assign ifetch_iram_request = issue;
    assign ifetch_iram_address = fetch_pc_q;
    assign ifetch_iram_wdata   = {{(32-TAG_W){1'b0}}, make_tag(epoch_q)};
    assign if_valid            = !q_empty;
    assign if_instr            = q_head.instr;
    assign if_pc               = q_head.pc;

    assign unused_bits = ^{ifetch_iram_rtag[TAG_W-1:EPOCH_LSB+EPOCH_W], jump_address[1:0]};

    // The credit rule reserves a slot for every outstanding request.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && q_full));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clock;
    logic        reset_n;
    logic        if_ready;
    logic        iram_ready;
    logic        jump_valid;
    logic [31:0] jump_address;
    logic        lat2;

    logic        req, rvalid, if_valid;
    logic [31:0] addr, wdata, rdata, raddr, if_instr, if_pc;
    logic [8:0]  rtag;

    logic        w_req, w_rvalid, w_if_valid;
    logic [31:0] w_addr, w_wdata, w_rdata, w_raddr, w_if_instr, w_if_pc;
    logic [8:0]  w_rtag;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset_n(reset_n),
        .ifetch_iram_request(req), .ifetch_iram_ready(iram_ready),
        .ifetch_iram_address(addr), .ifetch_iram_wdata(wdata),
        .ifetch_iram_rvalid(rvalid), .ifetch_iram_rdata(rdata),
        .ifetch_iram_raddr(raddr), .ifetch_iram_rtag(rtag),
        .jump_valid(jump_valid), .jump_address(jump_address),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock(clock), .reset_n(reset_n),
        .ifetch_iram_request(w_req), .ifetch_iram_ready(iram_ready),
        .ifetch_iram_address(w_addr), .ifetch_iram_wdata(w_wdata),
        .ifetch_iram_rvalid(w_rvalid), .ifetch_iram_rdata(w_rdata),
        .ifetch_iram_raddr(w_raddr), .ifetch_iram_rtag(w_rtag),
        .jump_valid(1'b0), .jump_address(32'h0),
        .if_valid(w_if_valid), .if_ready(if_ready),
        .if_instr(w_if_instr), .if_pc(w_if_pc)
    );

    // Memory responder: 1-cycle latency, or 2-cycle when lat2 is set.
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_a = '0, s2_a = '0;
    logic [8:0]  s1_t = '0, s2_t = '0;
    always @(posedge clock) begin
        s1_v <= req;  s1_a <= addr;  s1_t <= wdata[8:0];
        s2_v <= s1_v; s2_a <= s1_a;  s2_t <= s1_t;
    end
    assign rvalid = lat2 ? s2_v : s1_v;
    assign raddr  = lat2 ? s2_a : s1_a;
    assign rtag   = lat2 ? s2_t : s1_t;
    assign rdata  = mem_word(raddr);

    logic        ws_v = 1'b0;
    logic [31:0] ws_a = '0;
    logic [8:0]  ws_t = '0;
    always @(posedge clock) begin
        ws_v <= w_req; ws_a <= w_addr; ws_t <= w_wdata[8:0];
    end
    assign w_rvalid = ws_v;
    assign w_raddr  = ws_a;
    assign w_rtag   = ws_t;
    assign w_rdata  = mem_word(w_raddr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, 32'(if_valid), 32'd1);
        chk({name, "_pc"}, if_pc, pc);
        chk({name, "_instr"}, if_instr, mem_word(pc));
    endtask

    task automatic do_reset();
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock) reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        reset_n = 1'b0; if_ready = 1'b1; iram_ready = 1'b1;
        jump_valid = 1'b0; jump_address = '0; lat2 = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);
        chk("rst_w_req", 32'(w_req), 32'd0);

        // Free-running from reset, plus PC wrap on the second instance
        reset_n = 1'b1; #1;
        chk("free_req", 32'(req), 32'd1);
        chk("free_tag", wdata, 32'h0);
        @(negedge clock);
        chk("free_lat_e1", 32'(if_valid), 32'd0);
        @(negedge clock);
        for (int k = 0; k < 6; k++) begin
            chk_head("free", 32'(k * 4));
            if (k < 3) begin
                chk("wrap_valid", 32'(w_if_valid), 32'd1);
                chk("wrap_pc", w_if_pc, 32'hFFFF_FFF8 + 32'(k * 4));
                chk("wrap_instr", w_if_instr, mem_word(32'hFFFF_FFF8 + 32'(k * 4)));
            end
            @(negedge clock);
        end

        // Backpressure: decoder stalled for 10 cycles
        if_ready = 1'b0;
        do_reset();
        n = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            if (req) n++;
        end
        chk("bp_requests", 32'(n), 32'd4);
        chk_head("bp_hold", 32'h0);
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_head("bp_release", 32'(k * 4));
            @(negedge clock);
        end

        // Redirect while the response for 0x8 is returning
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (rvalid && raddr == 32'h8) found = 1'b1;
        end
        chk("redir_found_0x8", 32'(found), 32'd1);
        jump_valid = 1'b1; jump_address = 32'h100; #1;
        chk("redir_no_req", 32'(req), 32'd0);
        @(negedge clock) jump_valid = 1'b0; #1;
        chk("redir_flushed", 32'(if_valid), 32'd0);
        chk("redir_req", 32'(req), 32'd1);
        chk("redir_addr", addr, 32'h100);
        chk("redir_tag", wdata, 32'h1);
        @(negedge clock);
        chk("redir_lat", 32'(if_valid), 32'd0);
        @(negedge clock);
        chk_head("redir_a", 32'h100);
        @(negedge clock);
        chk_head("redir_b", 32'h104);

        // Back-to-back jumps, second target unaligned
        jump_valid = 1'b1; jump_address = 32'h200;
        @(negedge clock) jump_address = 32'h303;
        @(negedge clock) jump_valid = 1'b0; #1;
        chk("b2b_flushed", 32'(if_valid), 32'd0);
        chk("b2b_addr", addr, 32'h300);
        chk("b2b_tag", wdata, 32'h3);
        @(negedge clock);
        chk("b2b_lat", 32'(if_valid), 32'd0);
        @(negedge clock);
        chk_head("b2b_a", 32'h300);
        @(negedge clock);
        chk_head("b2b_b", 32'h304);

        // Stale response arriving after a redirect (2-cycle memory)
        lat2 = 1'b1;
        do_reset();
        @(negedge clock);
        jump_valid = 1'b1; jump_address = 32'h40; #1;
        chk("stale_no_req", 32'(req), 32'd0);
        @(negedge clock) jump_valid = 1'b0; #1;
        chk("stale_addr", addr, 32'h40);
        @(negedge clock);
        chk("stale_dropped", 32'(if_valid), 32'd0);
        @(negedge clock);
        chk("stale_lat", 32'(if_valid), 32'd0);
        @(negedge clock);
        chk_head("stale_a", 32'h40);
        @(negedge clock);
        chk_head("stale_b", 32'h44);
        lat2 = 1'b0;

        // Responder stall for 5 cycles
        iram_ready = 1'b0;
        do_reset();
        n = 0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (req) n++;
            @(negedge clock);
        end
        chk("stall_requests", 32'(n), 32'd0);
        chk("stall_addr", addr, 32'h0);
        chk("stall_valid", 32'(if_valid), 32'd0);
        iram_ready = 1'b1; #1;
        chk("stall_resume_req", 32'(req), 32'd1);
        @(negedge clock);
        @(negedge clock);
        chk_head("stall_first", 32'h0);

        // Mid-stream reset with the queue full
        if_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge clock);
        chk_head("mid_full", 32'h0);
        reset_n = 1'b0; #1;
        chk("mid_valid_drop", 32'(if_valid), 32'd0);
        chk("mid_req_low", 32'(req), 32'd0);
        @(negedge clock) reset_n = 1'b1; if_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk_head("mid_restart", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit for the Falcon CPU. It is the initiator side of the ifetch interface to `instruction_ram`. It keeps a fetch PC and issues one 32-bit fetch per cycle while credit allows. Returned words are queued in a small prefetch FIFO, and {pc, instr} pairs are handed to the decoder over a valid/ready handshake. Branch redirects flush the queue, and an epoch carried in the request tag discards responses that were already in flight.

## Interface
- `DEPTH`, 4: prefetch FIFO entries. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `ifetch_iram_request`, out, 1: fetch request this cycle.
- `ifetch_iram_ready`, in, 1: responder can accept a request.
- `ifetch_iram_address`, out, 32: byte address to fetch; always 4-byte aligned.
- `ifetch_iram_wdata`, out, 32: request tag; [8:0] = tag, [31:9] = 0.
- `ifetch_iram_rvalid`, in, 1: response valid.
- `ifetch_iram_rdata`, in, 32: instruction word.
- `ifetch_iram_raddr`, in, 32: address of the returned word.
- `ifetch_iram_rtag`, in, 9: tag echoed by the responder.
- `jump_valid`, in, 1: redirect the fetch stream.
- `jump_address`, in, 32: redirect target; bits [1:0] are ignored and forced to 0.
- `if_valid`, out, 1: an instruction is available to the decoder.
- `if_ready`, in, 1: the decoder accepts the instruction.
- `if_instr`, out, 32: instruction word.
- `if_pc`, out, 32: address of `if_instr`.

## Operation
**State**
- `fetch_pc` (32 bits).
- `epoch` (3 bits).
- `inflight` counter (0..DEPTH).
- FIFO of {pc, instr} entries with a `count` of occupied entries.

**Tag format**
- tag[2:0] = `epoch`; tag[8:3] = 0.

**Issuing requests**
- Request condition: `ifetch_iram_request` = `ifetch_iram_ready` && (`count` + `inflight` < DEPTH) && !`jump_valid`.
- `ifetch_iram_address` = `fetch_pc`.
- On issue: `fetch_pc` += 4 (wraps modulo 2^32) and `inflight`++.

**Handling responses**
- Any `ifetch_iram_rvalid` decrements `inflight`, whether or not its tag matches.
- If `rtag[2:0]` == `epoch` and `jump_valid` is low, push {`raddr`, `rdata`} into the FIFO.
- Otherwise drop the response silently.

**Redirect**
- When `jump_valid` is high:
  - `fetch_pc` ← {`jump_address`[31:2], 2'b00}.
  - `epoch`++ (wraps).
  - FIFO is emptied.
  - Any same-cycle pop or push is ignored.
- `inflight` is not cleared; stale responses drain through the epoch check.

**Decoder side**
- `if_valid` = FIFO not empty.
- `if_instr` and `if_pc` = FIFO head.
- The head is popped when `if_valid` && `if_ready` && !`jump_valid`.
- Push and pop in the same cycle are legal; `count` is unchanged.

**Overflow**
- The credit rule guarantees a push never finds the FIFO full. A push while full is a design error, covered by an assertion.

## Timing
**Reset values**
- `fetch_pc` = RESET_PC, `epoch` = 0, `inflight` = 0, `count` = 0.
- Outputs: `if_valid` = 0; `ifetch_iram_request` = 0 while `reset_n` is low.
- `if_instr` and `if_pc` are don't-care while `if_valid` is 0.

**Latency**
- Request sampled by the responder at edge N; response arrives in cycle N+1.
- The response is written at edge N+1; `if_valid` rises in cycle N+2.
- Fetch-to-decode latency is 2 cycles. There is no bypass.

**Throughput**
- One instruction per cycle in steady state with `if_ready` held high and DEPTH ≥ 2.

**Redirect timing**
- No request is issued in the `jump_valid` cycle.
- The first request to the target goes out the next cycle, and its instruction appears 2 cycles after that.
- Back-to-back jumps: each one increments `epoch` and the last target wins.

**Backpressure**
- With `if_ready` = 0, requests stop once `count` + `inflight` = DEPTH.
- Fetching resumes in the cycle after the first pop.

**Other boundaries**
- `ifetch_iram_ready` = 0: no request is issued and `fetch_pc` holds.
- Reset asserted mid-operation: all state clears immediately. Responses arriving after reset release carry epoch ≠ 0 or are counted by `inflight` = 0. An rvalid while `inflight` = 0 is ignored; `inflight` saturates at 0.

## Structure
- Shared package `ifetch_pkg`:
  - `EPOCH_W` = 3.
  - Tag layout constants: `TAG_W` = 9, epoch field position.
  - `ifetch_entry_t` packed struct {pc[31:0], instr[31:0]}.
- Sub-module `ifetch_queue`: a synchronous FIFO of `ifetch_entry_t` with push, pop, flush, count, empty and full outputs.
- The top level holds the PC, epoch and credit logic.

## Test plan
- **Reset, free-running:** release reset with RESET_PC = 0 and a memory model with 1-cycle latency, `if_ready` = 1. `if_pc` sequence is 0, 4, 8, 12… starting in cycle 2, one per cycle, with `if_instr` matching memory.
- **Backpressure:** hold `if_ready` = 0 for 10 cycles. Exactly 4 requests are issued, `if_valid` stays 1, and `if_pc` stays 0. Release: PCs 0, 4, 8, 12, 16 follow without gaps or duplicates.
- **Redirect with in-flight data:** pulse `jump_valid` with `jump_address` = 0x100 in the cycle a response for PC 0x8 returns. 0x8 never reaches `if_pc`; the next `if_pc` values are 0x100, 0x104.
- **Back-to-back jumps and unaligned target:** jumps to 0x200 then 0x303 in consecutive cycles. First delivered PC is 0x300, and `epoch` has advanced by 2.
- **Responder stall and PC wrap:** hold `ifetch_iram_ready` = 0 for 5 cycles; no requests are issued and the PC is unchanged. With RESET_PC = 0xFFFF_FFF8, delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- **Mid-stream reset:** assert `reset_n` low for 1 cycle with the FIFO full. `if_valid` drops immediately, and after release the first PC delivered is RESET_PC.
